addsub_pipe_nbit: RTL and testbench

Pipelined, parametrised n-bit adder/subtractor with a valid/ready handshake, intended as the datapath arithmetic unit for wide operands where a single ripple chain does not close timing. Operands are split into equal-width chunks; each pipeline stage ripples one chunk and registers the carry for the next stage, so sustained throughput is one operation per clock. The block sits between an operand-issuing producer and a result consumer, and tolerates consumer backpressure without losing or duplicating results.

---
 rtl/addsub_pkg.sv | 18 +
 rtl/addsub_chunk.sv | 28 ++
 rtl/addsub_pipe_nbit.sv | 121 ++++++++++++
 tb/tb_addsub_pipe_nbit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: mode encoding,
// chunk-width helper and a configuration sanity check used at elaboration.
package addsub_pkg;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } mode_e;

  function automatic int chunk_w(input int n, input int stages);
    return (stages > 0) ? n / stages : n;
  endfunction

  function automatic bit cfg_ok(input int n, input int stages);
    return (stages >= 1) && (n % stages == 0);
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// One w-bit ripple slice of the adder/subtractor; y is conditioned by the
// mode bit so the same slice serves both add and subtract.
module addsub_chunk
  import addsub_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic              c_in,
  input  logic              add_n,
  output logic [DATA_W-1:0] s,
  output logic              c_out,
  output logic              c_msb_in
);

  logic [DATA_W-1:0] y_c;
  logic [DATA_W:0]   sum;

  assign y_c = y ^ {DATA_W{add_n == SUB}};
  assign sum = {1'b0, x} + {1'b0, y_c} + {{DATA_W{1'b0}}, c_in};

  assign s     = sum[DATA_W-1:0];
  assign c_out = sum[DATA_W];
  // Carry into the top bit recovered from the sum bit and its two operands.
  assign c_msb_in = x[DATA_W-1] ^ y_c[DATA_W-1] ^ sum[DATA_W-1];

endmodule

// File: rtl/addsub_pipe_nbit.sv
// Pipelined n-bit adder/subtractor with valid/ready handshake and global stall.
// Optional signed-overflow output is enabled by defining ADDSUB_OVF_EN.
module addsub_pipe_nbit
  import addsub_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic              add_n,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] s,
  output logic              c_out,
  output logic              out_valid,
  input  logic              out_ready
`ifdef ADDSUB_OVF_EN
  ,
  output logic              ovf
`endif
);

  localparam int W = chunk_w(DATA_W, STAGES);

  if (!cfg_ok(DATA_W, STAGES)) begin : g_cfg_err
    $error("addsub_pipe_nbit: DATA_W must be a positive multiple of STAGES");
  end

  logic stall;

  // a_p holds a rotating word: finished result chunks enter at the top while
  // unconsumed x chunks shift down, so the next chunk is always at bit 0.
  logic [DATA_W-1:0] a_p   [STAGES];
  logic [DATA_W-1:0] b_p   [STAGES];
  logic              md_p  [STAGES];
  logic              c_p   [STAGES];
  logic              vld_p [STAGES];
  logic [STAGES-1:0] c_msb;
  logic              c_msb_unused;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic              c_in;
    logic              md_in;
    logic              vld_in;
    logic [W-1:0]      sum;
    logic              c_nxt;

    if (k == 0) begin : g_first
      assign a_in   = x;
      assign b_in   = y;
      assign c_in   = add_n;
      assign md_in  = add_n;
      assign vld_in = in_valid;
    end else begin : g_next
      assign a_in   = a_p[k-1];
      assign b_in   = b_p[k-1];
      assign c_in   = c_p[k-1];
      assign md_in  = md_p[k-1];
      assign vld_in = vld_p[k-1];
    end

    addsub_chunk #(
      .DATA_W (W)
    ) u_chunk (
      .x        (a_in[W-1:0]),
      .y        (b_in[W-1:0]),
      .c_in     (c_in),
      .add_n    (md_in),
      .s        (sum),
      .c_out    (c_nxt),
      .c_msb_in (c_msb[k])
    );

    // ---- stage k register boundary ----
    always_ff @(posedge clk) begin
      if (rst) begin
        a_p[k]   <= '0;
        b_p[k]   <= '0;
        md_p[k]  <= 1'b0;
        c_p[k]   <= 1'b0;
        vld_p[k] <= 1'b0;
      end else if (!stall) begin
        a_p[k]   <= (a_in >> W) | (DATA_W'(sum) << (DATA_W - W));
        b_p[k]   <= b_in >> W;
        md_p[k]  <= md_in;
        c_p[k]   <= c_nxt;
        vld_p[k] <= vld_in;
      end
    end
  end

  assign s         = a_p[STAGES-1];
  assign c_out     = c_p[STAGES-1];
  assign out_valid = vld_p[STAGES-1];

  // Only the last slice's MSB carry matters, and only when ovf is built.
  assign c_msb_unused = ^c_msb;

`ifdef ADDSUB_OVF_EN
  logic msb_c_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      msb_c_p <= 1'b0;
    end else if (!stall) begin
      msb_c_p <= c_msb[STAGES-1];
    end
  end

  assign ovf = msb_c_p ^ c_p[STAGES-1];
`endif

endmodule

// File: tb/tb_addsub_pipe_nbit.sv
// Directed bench for addsub_pipe_nbit (n=8, stages=2) with a result scoreboard.
`timescale 1ns/1ps
module tb_addsub_pipe_nbit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] x = '0;
  logic [7:0] y = '0;
  logic       add_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] s;
  logic       c_out;
  logic       out_valid;
  logic       out_ready = 1'b1;
`ifdef ADDSUB_OVF_EN
  logic       ovf;
`endif

  int total = 0;
  int bad   = 0;
  int outs  = 0;
  int cyc   = 0;
  logic [9:0] sb[$];

  addsub_pipe_nbit #(
    .DATA_W (8),
    .STAGES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .y         (y),
    .add_n     (add_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .c_out     (c_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef ADDSUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: {ovf, carry, sum} of an exact 8-bit add or subtract.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic m);
    logic [7:0] bb;
    logic [8:0] r;
    logic       v;
    bb = m ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + {8'd0, m};
    v  = (a[7] == bb[7]) && (r[7] != a[7]);
    return {v, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic m);
    int guard;
    guard    = 0;
    x        = a;
    y        = b;
    add_n    = m;
    in_valid = 1'b1;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("send_ready", 32'(in_ready), 32'd1);
    sb.push_back(model(a, b, m));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while (sb.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every output transfer must match the oldest entry.
  always @(negedge clk) begin
    logic [9:0] e;
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL sb_unexpected: observed=%0h expected=none", s);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("result_s", 32'(s), 32'(e[7:0]));
        chk("result_c", 32'(c_out), 32'(e[8]));
`ifdef ADDSUB_OVF_EN
        chk("result_ovf", 32'(ovf), 32'(e[9]));
`endif
        outs++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         c0;
    int         o0;
    logic [9:0] ea;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rm;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_c", 32'(c_out), 32'd0);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ADDSUB_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(posedge clk);
    #1;

    // Signed overflow across the chunk boundary, with explicit latency check
    send(8'h7F, 8'h01, 1'b0);
    @(negedge clk);
    chk("lat_early_vld", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_vld", 32'(out_valid), 32'd1);
    chk("lat_s", 32'(s), 32'h80);
    chk("lat_c", 32'(c_out), 32'd0);
`ifdef ADDSUB_OVF_EN
    chk("lat_ovf", 32'(ovf), 32'd1);
`endif
    @(posedge clk);
    #1;

    // Borrow, equal operands, cross-chunk carry, full wrap
    send(8'h05, 8'h07, 1'b1);
    send(8'h10, 8'h10, 1'b1);
    send(8'h0F, 8'h01, 1'b0);
    send(8'hFF, 8'h01, 1'b0);
    drain("directed_drain");

    // Back-to-back random stream
    c0 = cyc;
    o0 = outs;
    for (int i = 0; i < 16; i++) begin
      send(8'($urandom), 8'($urandom), 1'($urandom));
    end
    chk("stream_rate", 32'(cyc - c0), 32'd16);
    drain("stream_drain");
    chk("stream_count", 32'(outs - o0), 32'd16);

    // Backpressure with a full pipeline
    o0        = outs;
    out_ready = 1'b0;
    ea        = model(8'h3C, 8'h4D, 1'b0);
    send(8'h3C, 8'h4D, 1'b0);
    send(8'h90, 8'h20, 1'b1);
    x        = 8'hA5;
    y        = 8'h5A;
    add_n    = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_vld", 32'(out_valid), 32'd1);
      chk("bp_s", 32'(s), 32'(ea[7:0]));
      chk("bp_c", 32'(c_out), 32'(ea[8]));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'hA5, 8'h5A, 1'b1);
    drain("bp_drain");
    chk("bp_count", 32'(outs - o0), 32'd3);

    // Reset with two operations in flight
    out_ready = 1'b0;
    send(8'h11, 8'h22, 1'b0);
    send(8'h33, 8'h44, 1'b1);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    chk("mid_rst_s", 32'(s), 32'd0);
    chk("mid_rst_c", 32'(c_out), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mid_rst_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Recovery after reset, plus directed signed-overflow subtract
    o0 = outs;
    send(8'h80, 8'h01, 1'b1);
    send(8'h00, 8'h00, 1'b0);
    ra = 8'($urandom);
    rb = 8'($urandom);
    rm = 1'($urandom);
    send(ra, rb, rm);
    drain("recover_drain");
    chk("recover_count", 32'(outs - o0), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
